// File: rtl/bullet_slot_scheduler.sv
// Bullet slot scheduler: once per VGA frame, ages the live bullets, then lets
// tank 1 and tank 2 (in that order) claim a free slot, with a per-tank cooldown.
module bullet_slot_scheduler #(
    parameter int SLOTS    = 3,
    parameter int LIFETIME = 600,
    parameter int COOLDOWN = 35,
    parameter int TW       = 10
) (
    input  logic                    CLK,
    input  logic                    RESET,
    input  logic                    vs,
    input  logic                    game_enable,
    input  logic [1:0]              shoot_req,
    input  logic [2*SLOTS-1:0]      slot_hit,
    output logic [2*SLOTS-1:0]      slot_create,
    output logic [2*SLOTS-1:0]      slot_active,
    output logic [2*SLOTS*TW-1:0]   slot_age,
    output logic [1:0]              shot_ack
);

    localparam int N  = 2 * SLOTS;
    localparam int PW = (SLOTS > 1) ? $clog2(SLOTS) : 1;
    localparam int IW = $clog2(N);
    localparam logic [TW-1:0] AGE_LAST  = TW'(LIFETIME - 1);
    localparam logic [TW-1:0] COOL_INIT = TW'(COOLDOWN);
    localparam logic [PW-1:0] PTR_LAST  = PW'(SLOTS - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_AGE    = 2'd1,
        S_ALLOC1 = 2'd2,
        S_ALLOC2 = 2'd3
    } state_t;

    state_t                 r_state;
    logic                   r_vs;
    logic [N-1:0]           r_active;
    logic [N-1:0]           r_create;
    logic [N-1:0][TW-1:0]   r_age;
    logic [1:0][TW-1:0]     r_cool;
    logic [1:0][PW-1:0]     r_ptr;
    logic [1:0]             r_req_prev;
    logic [1:0]             r_ack;

    logic                   w_alloc;
    logic                   w_tank;
    logic [SLOTS-1:0]       w_free;
    logic [PW:0]            w_idx;
    logic                   w_found;
    logic [PW-1:0]          w_pick;
    logic [PW-1:0]          w_ptr_next;
    logic                   w_press;
    logic                   w_accept;
    logic [IW-1:0]          w_gidx;
    logic [N-1:0]           w_sel;

    // Round-robin free-slot search for the tank being served in this ALLOC cycle
    always_comb begin
        w_alloc = (r_state == S_ALLOC1) || (r_state == S_ALLOC2);
        w_tank  = (r_state == S_ALLOC2);
        w_free  = w_tank ? ~r_active[N-1:SLOTS] : ~r_active[SLOTS-1:0];
        w_found = 1'b0;
        w_pick  = '0;
        w_idx   = '0;
        // Descending so the candidate closest to the pointer is written last
        for (int j = SLOTS - 1; j >= 0; j--) begin
            w_idx = {1'b0, r_ptr[w_tank]} + (PW+1)'(j);
            w_idx = (w_idx >= (PW+1)'(SLOTS)) ? (w_idx - (PW+1)'(SLOTS)) : w_idx;
            if (w_free[w_idx[PW-1:0]]) begin
                w_found = 1'b1;
                w_pick  = w_idx[PW-1:0];
            end else begin
                w_found = w_found;
            end
        end
        w_ptr_next = (w_pick == PTR_LAST) ? '0 : (w_pick + PW'(1));
        w_press    = shoot_req[w_tank] & ~r_req_prev[w_tank];
        w_accept   = w_alloc & w_press & game_enable & (r_cool[w_tank] == '0) & w_found;
        w_gidx     = w_tank ? (IW'(w_pick) + IW'(SLOTS)) : IW'(w_pick);
        w_sel      = w_accept ? ({{(N-1){1'b0}}, 1'b1} << w_gidx) : '0;
    end

    // Frame FSM, slot state, cooldowns, pointers and the create/ack pulses
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state    <= S_IDLE;
            r_vs       <= 1'b0;
            r_active   <= '0;
            r_create   <= '0;
            r_age      <= '0;
            r_cool     <= '0;
            r_ptr      <= '0;
            r_req_prev <= 2'b00;
            r_ack      <= 2'b00;
        end else begin
            r_vs     <= vs;
            r_create <= '0;
            r_ack    <= 2'b00;

            case (r_state)
                S_IDLE: begin
                    if (vs && !r_vs) begin
                        r_state <= S_AGE;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_AGE: begin
                    r_state <= S_ALLOC1;
                    for (int k = 0; k < 2; k++) begin
                        if (r_cool[k] != '0) begin
                            r_cool[k] <= r_cool[k] - TW'(1);
                        end
                    end
                end
                S_ALLOC1: r_state <= S_ALLOC2;
                S_ALLOC2: r_state <= S_IDLE;
                default:  r_state <= S_IDLE;
            endcase

            // The sample is refreshed even when the press is rejected, so a held button fires once
            if (w_alloc) begin
                r_req_prev[w_tank] <= shoot_req[w_tank];
            end
            if (w_accept) begin
                r_ack[w_tank]  <= 1'b1;
                r_cool[w_tank] <= COOL_INIT;
                r_ptr[w_tank]  <= w_ptr_next;
            end

            // A freshly chosen slot was free, so any concurrent hit belongs to the old bullet
            for (int i = 0; i < N; i++) begin
                if (w_sel[i]) begin
                    r_active[i] <= 1'b1;
                    r_age[i]    <= '0;
                    r_create[i] <= 1'b1;
                end else if (slot_hit[i] ||
                             ((r_state == S_AGE) && r_active[i] && (r_age[i] == AGE_LAST))) begin
                    r_active[i] <= 1'b0;
                    r_age[i]    <= '0;
                end else if ((r_state == S_AGE) && r_active[i]) begin
                    r_age[i] <= r_age[i] + TW'(1);
                end
            end
        end
    end

    assign slot_create = r_create;
    assign slot_active = r_active;
    assign slot_age    = r_age;
    assign shot_ack    = r_ack;

endmodule

// File: doc/bullet_slot_scheduler.md
# bullet_slot_scheduler

Allocates and retires the bullet slots shared by both tanks. It turns the tanks' shoot-request levels into one-cycle create pulses for bullet datapath instances and owns each slot's active flag and lifetime age. It enforces a per-tank cooldown and a per-tank slot budget, and processes one scheduling pass per VGA frame. It sits between the tank modules, the bullet instances and the tank/bullet collision checkers, on the 50 MHz VGA clock.

## Interface
- SLOTS, default 3: bullet slots per tank. Tank 1 owns slots 0..SLOTS-1; tank 2 owns SLOTS..2*SLOTS-1.
- LIFETIME, default 600: number of frames a bullet lives.
- COOLDOWN, default 35: minimum number of frames between accepted shots from one tank.
- TW, default 10: width of the age and cooldown counters. LIFETIME and COOLDOWN must be < 2^TW.

- CLK  in  1  the single system clock (50 MHz).
- RESET  in  1  asynchronous, active-high reset.
- vs  in  1  VGA vertical sync. Generated in the CLK domain. Its rising edge marks a frame.
- game_enable  in  1  when 0, no new allocations are made. Existing slots keep ageing.
- shoot_req  in  2  shoot request level. bit0 = tank 1, bit1 = tank 2.
- slot_hit  in  2*SLOTS  bullet/tank collision per slot. Any cycle high clears that slot.
- slot_create  out  2*SLOTS  one-CLK pulse when the slot is allocated.
- slot_active  out  2*SLOTS  slot holds a live bullet.
- slot_age  out  2*SLOTS*TW  flattened per-slot age in frames. Slot i occupies bits [i*TW +: TW].
- shot_ack  out  2  one-CLK pulse per tank for each accepted shot.

## Operation
- Frame tick: E is the first CLK edge at which the registered copy of vs is 0 and vs is 1.
- FSM states: IDLE, AGE, ALLOC1, ALLOC2, one cycle each.
  - IDLE -> AGE on frame tick.
  - AGE -> ALLOC1 -> ALLOC2 -> IDLE unconditionally.
- AGE, for every active slot:
  - if age == LIFETIME-1, clear active and set age to 0;
  - otherwise increment age.
  - Per-tank cooldown decrements, saturating at 0.
- ALLOC1 handles tank 1; ALLOC2 handles tank 2. For tank k:
  - sample shoot_req[k]. A press is sampled 1 with the previous frame's sample 0. Update the stored sample.
  - Accept when: press, game_enable = 1, cooldown == 0, and at least one of the tank's slots is free.
  - Slot choice is round-robin. Search starts at ptr[k]; the first free slot in the tank's range is chosen, wrapping modulo SLOTS.
  - On accept:
    - active = 1, age = 0, create pulse, shot_ack[k] pulse;
    - cooldown = COOLDOWN;
    - ptr[k] = chosen + 1, modulo SLOTS.
  - A rejected press is discarded, not queued. A held button fires once only.
- Hit: slot_hit[i] clears active[i] and sets age[i] to 0 on any cycle, in any state. A hit on an inactive slot has no effect.
- Simultaneous events:
  - Hit and expiry on the same slot in AGE: the slot is cleared once. No other effect.
  - Hit on a slot in the same ALLOC cycle in which that slot is chosen: allocation wins. The slot was free when chosen, so the hit refers to the old bullet.
- A frame tick arriving while the FSM is not in IDLE is ignored. This cannot occur with real VGA timing.

## Timing
- Reset (asynchronous, active-high), effective immediately:
  - all outputs 0, every age 0;
  - FSM in IDLE, ptrs 0, cooldowns 0;
  - stored shoot samples and the registered vs copy are 0.
- Reset mid-pass abandons the pass. Nothing is allocated until a new frame tick after release.
- All outputs are registered.
- With frame tick detected at edge E:
  - AGE results are visible after edge E+1.
  - Tank 1 slot_create, slot_active and shot_ack are visible after edge E+2.
  - Tank 2 is visible after edge E+3.
  - Pulses last exactly one CLK.
- Clearing by slot_hit is visible one CLK after hit is sampled.
- Shot spacing: a shot accepted in frame F allows the next accept in frame F+COOLDOWN at the earliest.

## Test plan
- Reset, then 3 frames with no requests -> all outputs 0 and ages 0. Assert RESET mid-pass at E+1 -> every output is 0 in the same cycle.
- Tank 1 presses in frame 1 -> slot_create[0] and shot_ack[0] pulse at E+2. slot_age[0] reads 5 after 5 further frames. slot_active[0] drops in the AGE of frame 1+LIFETIME.
- Tank 1 holds shoot_req for 200 frames -> exactly one shot. Tank 1 presses every 10 frames -> accepts at frames 1, 41, 81 (COOLDOWN 35). Slots are used in order 0, 1, 2, then 0 after expiry.
- Presses by both tanks in the same frame -> slot 0 created at E+2 and slot 3 created at E+3. With all 3 of tank 2's slots active, a further tank 2 press -> no create, no ack, and the press is not replayed later.
- slot_hit[1] pulsed while slot 1 is active -> active[1] = 0 next CLK. The next tank 1 accept takes ptr order, skipping busy slots.
- Hit applied to a slot during the ALLOC cycle in which it is chosen -> slot_active is 1 and slot_create pulses. With game_enable = 0, a press -> no allocation, while existing slots keep ageing.
